m_share_gen: RTL

Boolean masking front end for the masked ripple-carry adder datapath. Takes two unmasked WIDTH-bit operands over a valid/ready handshake, draws fresh masks from an internal 16-bit Galois LFSR, and emits two-share representations (a = a0 ^ a1, b = b0 ^ b1) ready to drive the masked adder's a0/a1/b0/b1 inputs. Sits between the unmasked operand source and the masked adder. Provides reseeding, an LFSR warm-up phase and a transaction counter.

---
 rtl/m_share_gen.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/m_share_gen.sv
// Boolean masking front end: splits two operands into two-share form using
// masks drawn from a 16-bit Galois LFSR, with reseed, warm-up and a transaction counter.
module m_share_gen #(
    parameter int unsigned WIDTH  = 4,
    parameter logic [15:0] SEED   = 16'hACE1,
    parameter int unsigned WARMUP = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             seed_load,
    input  logic [15:0]      seed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a0,
    output logic [WIDTH-1:0] a1,
    output logic [WIDTH-1:0] b0,
    output logic [WIDTH-1:0] b1,
    output logic             busy,
    output logic [15:0]      tx_count
);

    typedef enum logic {
        ST_WARM,
        ST_RUN
    } state_t;

    localparam logic [7:0]  L_WARMUP = 8'(WARMUP);
    localparam logic [15:0] L_TAPS   = 16'hB400;
    localparam state_t      L_START  = (WARMUP == 0) ? ST_RUN : ST_WARM;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_warm_cnt;
    logic [7:0]       w_warm_cnt_nxt;

    logic [15:0]      r_lfsr;
    logic [15:0]      w_lfsr_nxt;
    logic [15:0]      w_lfsr_step;
    logic [15:0]      w_seed_eff;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_a0;
    logic [WIDTH-1:0] r_a1;
    logic [WIDTH-1:0] r_b0;
    logic [WIDTH-1:0] r_b1;
    logic [15:0]      r_tx_count;

    logic             w_in_ready;
    logic             w_busy;
    logic             w_accept;
    logic [WIDTH-1:0] w_mask_a;
    logic [WIDTH-1:0] w_mask_b;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= L_START;
            r_warm_cnt <= L_WARMUP;
        end else begin
            r_state    <= w_state_nxt;
            r_warm_cnt <= w_warm_cnt_nxt;
        end
    end

    // Next-state logic; WARM leaves on the edge where the counter reaches 0,
    // so in_ready first rises exactly WARMUP cycles after reset or reseed.
    always_comb begin
        w_state_nxt    = r_state;
        w_warm_cnt_nxt = r_warm_cnt;
        if (seed_load) begin
            w_state_nxt    = L_START;
            w_warm_cnt_nxt = L_WARMUP;
        end else if (r_state == ST_WARM) begin
            if (r_warm_cnt <= 8'd1) begin
                w_state_nxt    = ST_RUN;
                w_warm_cnt_nxt = '0;
            end else begin
                w_warm_cnt_nxt = r_warm_cnt - 8'd1;
            end
        end
    end

    // Output logic
    always_comb begin
        w_busy     = (r_state == ST_WARM);
        w_in_ready = (r_state == ST_RUN) && !seed_load && (!r_out_valid || out_ready);
        w_accept   = in_valid && w_in_ready;
    end

    assign w_lfsr_step = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? L_TAPS : '0);
    assign w_seed_eff  = (seed == '0) ? SEED : seed;
    assign w_mask_a    = r_lfsr[WIDTH-1:0];
    assign w_mask_b    = r_lfsr[2*WIDTH-1:WIDTH];

    always_comb begin
        w_lfsr_nxt = r_lfsr;
        if (seed_load) begin
            w_lfsr_nxt = w_seed_eff;
        end else if (w_busy || w_accept) begin
            w_lfsr_nxt = w_lfsr_step;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr      <= SEED;
            r_out_valid <= 1'b0;
            r_a0        <= '0;
            r_a1        <= '0;
            r_b0        <= '0;
            r_b1        <= '0;
            r_tx_count  <= '0;
        end else begin
            r_lfsr <= w_lfsr_nxt;
            if (w_accept) begin
                r_a0        <= a ^ w_mask_a;
                r_a1        <= w_mask_a;
                r_b0        <= b ^ w_mask_b;
                r_b1        <= w_mask_b;
                r_out_valid <= 1'b1;
                r_tx_count  <= r_tx_count + 16'd1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign busy      = w_busy;
    assign out_valid = r_out_valid;
    assign a0        = r_a0;
    assign a1        = r_a1;
    assign b0        = r_b0;
    assign b1        = r_b1;
    assign tx_count  = r_tx_count;

endmodule
